// File: rtl/vputy_cmd_arb.sv
// vputy_cmd_arb: round-robin, burst-locked arbiter for the vputy command port.
// Forwards the owner's bundle through one register stage and drains between owners.
module vputy_cmd_arb #(
  parameter int NUM_REQ      = 4,
  parameter int MRX_IND_WTH  = 5,
  parameter int MRX_ADDR_WTH = 9,
  parameter int DRAIN_CYC    = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [NUM_REQ*5-1:0]            code_i,
  input  logic [NUM_REQ*MRX_IND_WTH-1:0]  mrs0_index_i,
  input  logic [NUM_REQ*MRX_ADDR_WTH-1:0] mrs0_addr_i,
  input  logic [NUM_REQ*6-1:0]            sv_code_i,
  input  logic [NUM_REQ*3-1:0]            mtx_sel_h_i,
  input  logic [NUM_REQ*MRX_IND_WTH-1:0]  mrd_index_i,
  input  logic [NUM_REQ*MRX_ADDR_WTH-1:0] mrd_addr_i,
  input  logic [NUM_REQ*8-1:0]            strobe_h_i,
  output logic [NUM_REQ-1:0]              gnt_o,
  output logic [4:0]                      arb_vputy__code_o,
  output logic [MRX_IND_WTH-1:0]          arb_vputy__mrs0_index_o,
  output logic [MRX_ADDR_WTH-1:0]         arb_vputy__mrs0_addr_o,
  output logic [5:0]                      arb_vputy__sv_code_o,
  output logic [2:0]                      arb_vputy__mtx_sel_h_o,
  output logic [MRX_IND_WTH-1:0]          arb_vputy__mrd_index_o,
  output logic [MRX_ADDR_WTH-1:0]         arb_vputy__mrd_addr_o,
  output logic [7:0]                      arb_vputy__strobe_h_o,
  output logic                            busy_o,
  output logic [2:0]                      owner_o
);

  typedef struct packed {
    logic [4:0]              code;
    logic [MRX_IND_WTH-1:0]  mrs0_index;
    logic [MRX_ADDR_WTH-1:0] mrs0_addr;
    logic [5:0]              sv_code;
    logic [2:0]              mtx_sel_h;
    logic [MRX_IND_WTH-1:0]  mrd_index;
    logic [MRX_ADDR_WTH-1:0] mrd_addr;
    logic [7:0]              strobe_h;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_DRAIN
  } state_t;

  localparam logic [2:0] LAST_REQ =
    3'(NUM_REQ - 1);
  localparam logic [4:0] DRAIN_LAST =
    5'(DRAIN_CYC - 1);

  state_t               state;
  logic [2:0]           rr_ptr;
  logic [2:0]           owner;
  logic [4:0]           drain_cnt;
  logic [NUM_REQ-1:0]   gnt;
  logic                 busy;
  cmd_t                 cmd_q;

  cmd_t                 own_cmd;
  logic                 own_req;
  logic                 any_req;
  logic                 hi_hit;
  logic [2:0]           win_hi;
  logic [2:0]           win_lo;
  logic [2:0]           win;
  logic [NUM_REQ-1:0]   win_oh;

  assign any_req = |req_i;

  // Select the current owner's request and command slice.
  always_comb begin
    own_req = 1'b0;
    own_cmd = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (owner == 3'(k)) begin
        own_req            = req_i[k];
        own_cmd.code       =
          code_i[k*5 +: 5];
        own_cmd.mrs0_index =
          mrs0_index_i[k*MRX_IND_WTH +: MRX_IND_WTH];
        own_cmd.mrs0_addr  =
          mrs0_addr_i[k*MRX_ADDR_WTH +: MRX_ADDR_WTH];
        own_cmd.sv_code    =
          sv_code_i[k*6 +: 6];
        own_cmd.mtx_sel_h  =
          mtx_sel_h_i[k*3 +: 3];
        own_cmd.mrd_index  =
          mrd_index_i[k*MRX_IND_WTH +: MRX_IND_WTH];
        own_cmd.mrd_addr   =
          mrd_addr_i[k*MRX_ADDR_WTH +: MRX_ADDR_WTH];
        own_cmd.strobe_h   =
          strobe_h_i[k*8 +: 8];
      end
    end
  end

  // Round-robin winner: lowest index above rr_ptr, else lowest overall.
  always_comb begin
    hi_hit = 1'b0;
    win_hi = '0;
    win_lo = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        win_lo = 3'(k);
        if (3'(k) > rr_ptr) begin
          hi_hit = 1'b1;
          win_hi = 3'(k);
        end
      end
    end
    win    = hi_hit ? win_hi : win_lo;
    win_oh = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win == 3'(k)) begin
        win_oh[k] = 1'b1;
      end
    end
  end

  // Arbitration FSM with registered grant, bundle and status.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= ST_IDLE;
      rr_ptr    <= LAST_REQ;
      owner     <= '0;
      drain_cnt <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      cmd_q     <= '0;
    end else begin
      cmd_q <= '0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            gnt    <= win_oh;
            owner  <= win;
            rr_ptr <= win;
            busy   <= 1'b1;
            state  <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (own_req) begin
            cmd_q <= own_cmd;
          end else begin
            gnt       <= '0;
            drain_cnt <= '0;
            state     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          drain_cnt <= drain_cnt + 5'd1;
          if (drain_cnt == DRAIN_LAST) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt_o   = gnt;
  assign busy_o  = busy;
  assign owner_o = owner;

  assign arb_vputy__code_o       = cmd_q.code;
  assign arb_vputy__mrs0_index_o = cmd_q.mrs0_index;
  assign arb_vputy__mrs0_addr_o  = cmd_q.mrs0_addr;
  assign arb_vputy__sv_code_o    = cmd_q.sv_code;
  assign arb_vputy__mtx_sel_h_o  = cmd_q.mtx_sel_h;
  assign arb_vputy__mrd_index_o  = cmd_q.mrd_index;
  assign arb_vputy__mrd_addr_o   = cmd_q.mrd_addr;
  assign arb_vputy__strobe_h_o   = cmd_q.strobe_h;

endmodule
